sl_pe_controller: RTL and testbench
===================================

SL_PE_CONTROLLER -- requirements
Module: sl_pe_controller

Interface
REQ-001 Parameter N, default 2: number of Corr_calculator lanes (filters) sequenced.
REQ-002 Parameter CNT_W, default 8: width of window count and memory address.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle job request, sampled in IDLE only.
REQ-006 num_windows  in  CNT_W  output positions in job, sampled with start.
REQ-007 win_valid / win_ready  in / out  1  window-row handshake (4 beats per window).
REQ-008 filt_valid / filt_ready  in / out  1  filter-row handshake (4 beats per filter).
REQ-009 write_window_buff_en, write_window_buff_ind  out  1 / 2  window buffer write strobe and row.
REQ-010 write_filter_buff_en, write_filter_buff_ind  out  N / 2  one-hot lane select and filter row.
REQ-011 reset_mac, partial_res_en  out  1 / 1  MAC clear, MAC accumulate enable.
REQ-012 read_four_to_four_buff_ind  out  4  MAC operand index 0..15.
REQ-013 shift_reg_en  out  1  push adder result into output shift register.
REQ-014 mem_wr_req, mem_wr_ack, mem_wr_addr  out / in / out  1 / 1 / CNT_W  packed 4-byte result write handshake.
REQ-015 busy, done  out  1 / 1  job active; single-cycle completion pulse.
REQ-016 perf_cycles  out  16  busy-cycle counter (see Configuration).

Function
REQ-017 States SHALL be IDLE, LOAD_FILT, LOAD_WIN, CLR, MAC, SHIFT, WRITE, DONE.
REQ-018 IDLE: start=1 with num_windows>0 -> LOAD_FILT; num_windows=0 -> DONE; start ignored in all other states.
REQ-019 LOAD_FILT: filt_ready=1; each filt_valid&filt_ready beat asserts write_filter_buff_en one-hot for lane f and ind=r, r 0..3 then f 0..N-1; after beat (N-1,3) -> LOAD_WIN.
REQ-020 LOAD_WIN: win_ready=1; each win_valid&win_ready beat asserts write_window_buff_en with ind 0..3; after beat 3 -> CLR.
REQ-021 Write strobes SHALL be combinational with the accepted beat; no strobe without valid&ready.
REQ-022 CLR: reset_mac=1 for exactly one cycle -> MAC.
REQ-023 MAC: partial_res_en=1 for 16 consecutive cycles, read_four_to_four_buff_ind=0..15 in order -> SHIFT.
REQ-024 SHIFT: shift_reg_en=1 one cycle; window counter increments; go WRITE if 4 windows packed or last window, else LOAD_WIN.
REQ-025 WRITE: mem_wr_req held high, mem_wr_addr stable, until mem_wr_ack sampled high; then addr+1 and -> LOAD_WIN, or DONE if last window.
REQ-026 Partial final group (num_windows mod 4 ≠ 0) SHALL still write; unfilled bytes are whatever the shift register holds.
REQ-027 DONE: done=1 one cycle, busy=0 -> IDLE; mem_wr_addr returns to 0 at next start.
REQ-028 busy=1 in every state except IDLE and DONE.
REQ-029 Window counter and address SHALL wrap modulo 2^CNT_W; no overflow flag.
REQ-030 Filters SHALL be loaded once per job; windows reloaded per output position.

Reset
REQ-031 rst low SHALL immediately force IDLE, counters 0, and all outputs 0, including mid-job and mid-handshake.
REQ-032 Handshake in progress at reset is abandoned; no strobe or mem_wr_req after rst deasserts until a new start.

Configuration
REQ-033 Macro SL_PE_CTRL_PERF_EN defined: perf_cycles counts busy cycles, clears on accepted start, saturates at 16'hFFFF.
REQ-034 Macro undefined: perf_cycles tied to 0, no counter flops.

Structure
REQ-035 Shared package sl_pe_pkg SHALL hold the state enum, ROWS=4, MAC_STEPS=16, PACK=4.
REQ-036 Single sub-module sl_pe_ctrl_perf (busy-cycle counter), instantiated only under SL_PE_CTRL_PERF_EN.

Verification
REQ-037 N=2, num_windows=4, valids always 1, ack same cycle -> busy high 97 cycles, one mem write at addr 0, done pulse once.
REQ-038 num_windows=0 start -> done pulse the cycle after start, no strobes, busy never 1.
REQ-039 num_windows=5 -> two writes, addr 0 then 1; second after exactly one SHIFT.
REQ-040 win_valid toggled every other cycle -> window ind still 0,1,2,3, strobes only on valid cycles.
REQ-041 mem_wr_ack delayed 7 cycles -> mem_wr_req and addr stable 7 cycles, no other strobes meanwhile.
REQ-042 rst low during MAC index 9 -> all outputs 0 same cycle; after release, idle until start.

Source files
------------

// File: rtl/sl_pe_pkg.sv
// Shared constants and state encoding for the systolic PE controller.
package sl_pe_pkg;

    localparam int ROWS      = 4;
    localparam int MAC_STEPS = 16;
    localparam int PACK      = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_LOAD_FILT = 3'd1;
    localparam state_t S_LOAD_WIN  = 3'd2;
    localparam state_t S_CLR       = 3'd3;
    localparam state_t S_MAC       = 3'd4;
    localparam state_t S_SHIFT     = 3'd5;
    localparam state_t S_WRITE     = 3'd6;
    localparam state_t S_DONE      = 3'd7;

endpackage

// File: rtl/sl_pe_ctrl_perf.sv
// Saturating busy-cycle counter; only instantiated when SL_PE_CTRL_PERF_EN is defined.
module sl_pe_ctrl_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        count_en,
    output logic [15:0] perf_cycles
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign perf_cycles = cnt_q;

endmodule

// File: rtl/sl_pe_controller.sv
// Sequencer for filter/window loading, 16-step MAC, result packing and memory writes.
// Optional busy-cycle counter enabled by defining SL_PE_CTRL_PERF_EN.
module sl_pe_controller
    import sl_pe_pkg::*;
#(
    parameter int N     = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_windows,
    input  logic             win_valid,
    output logic             win_ready,
    input  logic             filt_valid,
    output logic             filt_ready,
    output logic             write_window_buff_en,
    output logic [1:0]       write_window_buff_ind,
    output logic [N-1:0]     write_filter_buff_en,
    output logic [1:0]       write_filter_buff_ind,
    output logic             reset_mac,
    output logic             partial_res_en,
    output logic [3:0]       read_four_to_four_buff_ind,
    output logic             shift_reg_en,
    output logic             mem_wr_req,
    input  logic             mem_wr_ack,
    output logic [CNT_W-1:0] mem_wr_addr,
    output logic             busy,
    output logic             done,
    output logic [15:0]      perf_cycles
);

    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;

    state_t            state_q, state_d;
    logic [1:0]        row_q, row_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [3:0]        mac_q, mac_d;
    logic [1:0]        pack_q, pack_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]  win_next;

    assign win_next = win_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        lane_d    = lane_q;
        mac_d     = mac_q;
        pack_d    = pack_q;
        win_cnt_d = win_cnt_q;
        num_d     = num_q;
        addr_d    = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d     = num_windows;
                    win_cnt_d = '0;
                    addr_d    = '0;
                    pack_d    = '0;
                    row_d     = '0;
                    lane_d    = '0;
                    mac_d     = '0;
                    state_d   = (num_windows != '0) ? S_LOAD_FILT : S_DONE;
                end
            end
            S_LOAD_FILT: begin
                if (filt_valid) begin
                    row_d = row_q + 2'd1;
                    if (row_q == 2'(ROWS - 1)) begin
                        if (lane_q == LANE_W'(N - 1)) begin
                            lane_d  = '0;
                            state_d = S_LOAD_WIN;
                        end else begin
                            lane_d = lane_q + 1'b1;
                        end
                    end
                end
            end
            S_LOAD_WIN: begin
                if (win_valid) begin
                    row_d = row_q + 2'd1;
                    if (row_q == 2'(ROWS - 1)) begin
                        state_d = S_CLR;
                    end
                end
            end
            S_CLR: begin
                mac_d   = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                mac_d = mac_q + 4'd1;
                if (mac_q == 4'(MAC_STEPS - 1)) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A partially filled final group is still flushed to memory.
                win_cnt_d = win_next;
                pack_d    = pack_q + 2'd1;
                state_d   = (pack_q == 2'(PACK - 1) || win_next == num_q) ? S_WRITE : S_LOAD_WIN;
            end
            S_WRITE: begin
                if (mem_wr_ack) begin
                    addr_d  = addr_q + 1'b1;
                    pack_d  = '0;
                    state_d = (win_cnt_q == num_q) ? S_DONE : S_LOAD_WIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            lane_q    <= '0;
            mac_q     <= '0;
            pack_q    <= '0;
            win_cnt_q <= '0;
            num_q     <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            lane_q    <= lane_d;
            mac_q     <= mac_d;
            pack_q    <= pack_d;
            win_cnt_q <= win_cnt_d;
            num_q     <= num_d;
            addr_q    <= addr_d;
        end
    end

    // Strobes are combinational with the accepted beat so the buffers capture data in the same cycle.
    assign filt_ready                 = (state_q == S_LOAD_FILT);
    assign win_ready                  = (state_q == S_LOAD_WIN);
    assign write_filter_buff_en       = (filt_ready && filt_valid) ? (N'(1) << lane_q) : '0;
    assign write_filter_buff_ind      = filt_ready ? row_q : 2'd0;
    assign write_window_buff_en       = win_ready && win_valid;
    assign write_window_buff_ind      = win_ready ? row_q : 2'd0;
    assign reset_mac                  = (state_q == S_CLR);
    assign partial_res_en             = (state_q == S_MAC);
    assign read_four_to_four_buff_ind = partial_res_en ? mac_q : 4'd0;
    assign shift_reg_en               = (state_q == S_SHIFT);
    assign mem_wr_req                 = (state_q == S_WRITE);
    assign mem_wr_addr                = addr_q;
    assign done                       = (state_q == S_DONE);
    assign busy                       = (state_q != S_IDLE) && (state_q != S_DONE);

`ifdef SL_PE_CTRL_PERF_EN
    sl_pe_ctrl_perf u_perf (
        .clk        (clk),
        .rst        (rst),
        .clear      ((state_q == S_IDLE) && start),
        .count_en   (busy),
        .perf_cycles(perf_cycles)
    );
`else
    assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_sl_pe_controller.sv
// Scoreboard bench: a loop-level job model pushes expected events, a monitor pops and compares.
module tb_sl_pe_controller;

    localparam int N     = 2;
    localparam int CNT_W = 8;

    localparam logic [3:0] K_FILT  = 4'd1;
    localparam logic [3:0] K_WIN   = 4'd2;
    localparam logic [3:0] K_CLR   = 4'd3;
    localparam logic [3:0] K_MAC   = 4'd4;
    localparam logic [3:0] K_SHIFT = 4'd5;
    localparam logic [3:0] K_WR    = 4'd6;
    localparam logic [3:0] K_DONE  = 4'd7;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_windows;
    logic             win_valid;
    logic             win_ready;
    logic             filt_valid;
    logic             filt_ready;
    logic             write_window_buff_en;
    logic [1:0]       write_window_buff_ind;
    logic [N-1:0]     write_filter_buff_en;
    logic [1:0]       write_filter_buff_ind;
    logic             reset_mac;
    logic             partial_res_en;
    logic [3:0]       read_four_to_four_buff_ind;
    logic             shift_reg_en;
    logic             mem_wr_req;
    logic             mem_wr_ack;
    logic [CNT_W-1:0] mem_wr_addr;
    logic             busy;
    logic             done;
    logic [15:0]      perf_cycles;

    ev_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  busy_cnt    = 0;
    int  hold_cnt    = 0;
    int  req_cnt     = 0;
    int  valid_mode  = 0;
    int  ack_delay   = 0;
    bit  done_seen   = 1'b0;

    sl_pe_controller #(.N(N), .CNT_W(CNT_W)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .num_windows               (num_windows),
        .win_valid                 (win_valid),
        .win_ready                 (win_ready),
        .filt_valid                (filt_valid),
        .filt_ready                (filt_ready),
        .write_window_buff_en      (write_window_buff_en),
        .write_window_buff_ind     (write_window_buff_ind),
        .write_filter_buff_en      (write_filter_buff_en),
        .write_filter_buff_ind     (write_filter_buff_ind),
        .reset_mac                 (reset_mac),
        .partial_res_en            (partial_res_en),
        .read_four_to_four_buff_ind(read_four_to_four_buff_ind),
        .shift_reg_en              (shift_reg_en),
        .mem_wr_req                (mem_wr_req),
        .mem_wr_ack                (mem_wr_ack),
        .mem_wr_addr               (mem_wr_addr),
        .busy                      (busy),
        .done                      (done),
        .perf_cycles               (perf_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog_timeout got=expired want=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkScalar(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, act, expv);
        end
    endtask

    task automatic checkOutput(input ev_t got);
        ev_t want;
        bit  ok;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_event got kind=%0d a=%0d b=%0d want=none", got.kind, got.a, got.b);
            return;
        end
        want = exp_q.pop_front();
        if (want.kind == K_DONE) begin
            ok = (got.kind == K_DONE) && (!want.b[0] || (got.a == want.a && got.c == want.c));
        end else begin
            ok = (got.kind == want.kind) && (got.a == want.a) && (got.b == want.b);
        end
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL event got kind=%0d a=%0d b=%0d c=%0d want kind=%0d a=%0d b=%0d c=%0d",
                     got.kind, got.a, got.b, got.c, want.kind, want.a, want.b, want.c);
        end
    endtask

    // Job model: filters once, then per window 4 rows, clear, 16 MAC steps, shift; write every 4 or at end.
    task automatic applyStimulus(input int w, input int mode, input int delay);
        int  writes;
        int  busy_exp;
        ev_t e;
        valid_mode = mode;
        ack_delay  = delay;
        writes     = 0;
        if (w > 0) begin
            for (int f = 0; f < N; f++)
                for (int r = 0; r < 4; r++) begin
                    e = '{K_FILT, 16'(f), 16'(r), 16'd0};
                    exp_q.push_back(e);
                end
            for (int i = 0; i < w; i++) begin
                for (int r = 0; r < 4; r++) begin
                    e = '{K_WIN, 16'(r), 16'd0, 16'd0};
                    exp_q.push_back(e);
                end
                e = '{K_CLR, 16'd0, 16'd0, 16'd0};
                exp_q.push_back(e);
                for (int m = 0; m < 16; m++) begin
                    e = '{K_MAC, 16'(m), 16'd0, 16'd0};
                    exp_q.push_back(e);
                end
                e = '{K_SHIFT, 16'd0, 16'd0, 16'd0};
                exp_q.push_back(e);
                if (i % 4 == 3 || i == w - 1) begin
                    e = '{K_WR, 16'(writes % 256), 16'(delay + 1), 16'd0};
                    exp_q.push_back(e);
                    writes++;
                end
            end
        end
        busy_exp = (w == 0) ? 0 : (4 * N + 22 * w + writes * (delay + 1));
`ifdef SL_PE_CTRL_PERF_EN
        e = '{K_DONE, 16'(busy_exp), 16'(mode == 0), 16'(busy_exp)};
`else
        e = '{K_DONE, 16'(busy_exp), 16'(mode == 0), 16'd0};
`endif
        exp_q.push_back(e);
        done_seen = 1'b0;
        @(posedge clk);
        #2;
        start       = 1'b1;
        num_windows = CNT_W'(w);
        @(posedge clk);
        #2;
        start       = 1'b0;
        num_windows = CNT_W'($urandom);
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (!done_seen && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!done_seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_done_timeout got=none want=done", name);
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [63:0] allOutputs();
        return 64'({win_ready, filt_ready, write_window_buff_en, write_window_buff_ind,
                    write_filter_buff_en, write_filter_buff_ind, reset_mac, partial_res_en,
                    read_four_to_four_buff_ind, shift_reg_en, mem_wr_req, mem_wr_addr,
                    busy, done, perf_cycles});
    endfunction

    always @(posedge clk) begin
        #2;
        case (valid_mode)
            0: begin
                win_valid  = 1'b1;
                filt_valid = 1'b1;
            end
            1: begin
                win_valid  = ~win_valid;
                filt_valid = ~filt_valid;
            end
            default: begin
                win_valid  = 1'($urandom_range(0, 1));
                filt_valid = 1'($urandom_range(0, 1));
            end
        endcase
    end

    always @(posedge clk) begin
        #2;
        if (mem_wr_req) begin
            mem_wr_ack = (req_cnt >= ack_delay);
            req_cnt++;
        end else begin
            mem_wr_ack = 1'b0;
            req_cnt    = 0;
        end
    end

    always @(negedge clk) begin
        ev_t got;
        bit  seen;
        int  lane;
        if (rst) begin
            if (busy) busy_cnt++;
            if (mem_wr_req) hold_cnt++;
            seen = 1'b1;
            if (write_filter_buff_en != '0) begin
                lane = 16'hFFFF;
                if ($countones(write_filter_buff_en) == 1)
                    for (int i = 0; i < N; i++)
                        if (write_filter_buff_en[i]) lane = i;
                got = '{K_FILT, 16'(lane), 16'(write_filter_buff_ind), 16'd0};
                checkScalar("filt_strobe_valid", 64'(filt_valid), 64'd1);
            end else if (write_window_buff_en) begin
                got = '{K_WIN, 16'(write_window_buff_ind), 16'd0, 16'd0};
                checkScalar("win_strobe_valid", 64'(win_valid), 64'd1);
            end else if (reset_mac) begin
                got = '{K_CLR, 16'd0, 16'd0, 16'd0};
            end else if (partial_res_en) begin
                got = '{K_MAC, 16'(read_four_to_four_buff_ind), 16'd0, 16'd0};
            end else if (shift_reg_en) begin
                got = '{K_SHIFT, 16'd0, 16'd0, 16'd0};
            end else if (mem_wr_req && mem_wr_ack) begin
                got = '{K_WR, 16'(mem_wr_addr), 16'(hold_cnt), 16'd0};
                hold_cnt = 0;
            end else if (done) begin
                got = '{K_DONE, 16'(busy_cnt), 16'd0, perf_cycles};
                busy_cnt  = 0;
                done_seen = 1'b1;
            end else begin
                seen = 1'b0;
            end
            if (seen) checkOutput(got);
        end
    end

    initial begin
        int n;
        rst         = 1'b0;
        start       = 1'b0;
        num_windows = '0;
        win_valid   = 1'b1;
        filt_valid  = 1'b1;
        mem_wr_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkScalar("reset_outputs", allOutputs(), 64'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        applyStimulus(4, 0, 0);
        waitDone("four_windows");
        applyStimulus(0, 0, 0);
        waitDone("zero_windows");
        applyStimulus(5, 0, 0);
        waitDone("five_windows");
        applyStimulus(4, 1, 0);
        waitDone("toggle_valid");
        applyStimulus(3, 0, 7);
        waitDone("ack_delay7");

        applyStimulus(6, 0, 2);
        repeat (30) @(posedge clk);
        #2;
        start       = 1'b1;
        num_windows = 8'd3;
        @(posedge clk);
        #2;
        start = 1'b0;
        waitDone("start_ignored");

        for (int j = 0; j < 6; j++) begin
            applyStimulus($urandom_range(1, 9), $urandom_range(0, 2), $urandom_range(0, 7));
            waitDone("random_job");
        end

        applyStimulus(4, 0, 0);
        n = 0;
        while (!(partial_res_en && read_four_to_four_buff_ind == 4'd9) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkScalar("reach_mac9", 64'(partial_res_en && read_four_to_four_buff_ind == 4'd9), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        checkScalar("reset_mid_mac", allOutputs(), 64'd0);
        exp_q.delete();
        busy_cnt = 0;
        hold_cnt = 0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checkScalar("idle_after_reset", allOutputs(), 64'd0);

        applyStimulus(2, 0, 1);
        waitDone("post_reset_job");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
